// File: rtl/wb_sdr_traffic_gen.sv
// wb_sdr_traffic_gen: Wishbone master that writes bursts of LFSR data from a
// base address, reads the same region back, and compares against the
// regenerated pattern. It reports the mismatch count, the first failing
// address and pass/fail.
// Optional feature macro: TG_ACK_TIMEOUT_EN adds the TO_CYC parameter and the
// timeout output, which abort the run when a slave stops acknowledging.
module wb_sdr_traffic_gen #(
  parameter int              dw        = 32,
  parameter int              APP_AW    = 26,
  parameter int              BL_W      = 4,
  parameter int              NB_W      = 16,
  parameter logic [dw-1:0]   LFSR_TAPS = dw'(32'h80200003)
`ifdef TG_ACK_TIMEOUT_EN
  , parameter int            TO_CYC    = 255
`endif
) (
  input  logic                wb_clk_i,
  input  logic                wb_resetn,
  input  logic                start,
  input  logic [APP_AW-1:0]   cfg_base_addr,
  input  logic [BL_W-1:0]     cfg_burst_len,
  input  logic [NB_W-1:0]     cfg_num_bursts,
  input  logic [dw-1:0]       cfg_seed,
  input  logic [dw/8-1:0]     cfg_sel,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [APP_AW-1:0]   wb_addr_o,
  output logic [dw-1:0]       wb_dat_o,
  output logic [dw/8-1:0]     wb_sel_o,
  output logic [2:0]          wb_cti_o,
  input  logic                wb_ack_i,
  input  logic [dw-1:0]       wb_dat_i,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  output logic [APP_AW-1:0]   first_err_addr
`ifdef TG_ACK_TIMEOUT_EN
  , output logic              timeout
`endif
);

  localparam int                BW         = dw / 8;
  localparam logic [APP_AW-1:0] ADDR_STEP  = APP_AW'(BW);
  localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(BW - 1);

  typedef enum logic [2:0] {
    IDLE, WR_BURST, WR_GAP, RD_INIT, RD_BURST, RD_GAP, FIN
  } state_t;

  state_t            state;
  logic [APP_AW-1:0] base_q;
  logic [BL_W-1:0]   len_q;
  logic [NB_W-1:0]   nb_q;
  logic [dw-1:0]     seed_q;
  logic [BW-1:0]     sel_q;
  logic [dw-1:0]     lfsr;
  logic [BL_W-1:0]   beat_cnt;
  logic [NB_W-1:0]   burst_cnt;

  logic [dw-1:0]     sel_mask;
  logic [dw-1:0]     lfsr_next;
  logic              mismatch;
  logic              last_beat;

`ifdef TG_ACK_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  logic [TO_W-1:0]          to_cnt;
`endif

  // Expand the latched byte enables into a bit mask and derive the next LFSR
  // value and the read-compare result.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    sel_mask = '0;
    for (int i = 0; i < BW; i++) sel_mask[8*i +: 8] = {8{sel_q[i]}};
    lfsr_next = {1'b0, lfsr[dw-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    mismatch  = |((wb_dat_i ^ lfsr) & sel_mask);
    last_beat = (beat_cnt == len_q);
  end

  assign wb_sel_o = sel_q;
  assign wb_dat_o = wb_we_o ? lfsr : '0;
  assign wb_cti_o = !wb_cyc_o ? 3'b000 : (last_beat ? 3'b111 : 3'b010);

  // Run sequencer: write phase, read-back/compare phase, then report.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state          <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      nb_q           <= '0;
      seed_q         <= '0;
      sel_q          <= '0;
      lfsr           <= dw'(1);
      beat_cnt       <= '0;
      burst_cnt      <= '0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
`ifdef TG_ACK_TIMEOUT_EN
      to_cnt         <= '0;
      timeout        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= cfg_base_addr & ALIGN_MASK;
            len_q          <= cfg_burst_len;
            nb_q           <= cfg_num_bursts;
            seed_q         <= (cfg_seed == '0) ? dw'(1) : cfg_seed;
            sel_q          <= cfg_sel;
            lfsr           <= (cfg_seed == '0) ? dw'(1) : cfg_seed;
            wb_addr_o      <= cfg_base_addr & ALIGN_MASK;
            beat_cnt       <= '0;
            burst_cnt      <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
`ifdef TG_ACK_TIMEOUT_EN
            to_cnt         <= '0;
            timeout        <= 1'b0;
`endif
            if (cfg_num_bursts == '0) begin
              state <= FIN;
            end else begin
              state    <= WR_BURST;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
            end
          end
        end

        WR_BURST, RD_BURST: begin
          if (wb_ack_i && wb_cyc_o) begin
            wb_addr_o <= wb_addr_o + ADDR_STEP;
            lfsr      <= lfsr_next;
`ifdef TG_ACK_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            if (state == RD_BURST && mismatch) begin
              if (err_cnt == 16'd0) first_err_addr <= wb_addr_o;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (last_beat) begin
              wb_cyc_o  <= 1'b0;
              wb_stb_o  <= 1'b0;
              wb_we_o   <= 1'b0;
              beat_cnt  <= '0;
              burst_cnt <= burst_cnt + NB_W'(1);
              state     <= (state == WR_BURST) ? WR_GAP : RD_GAP;
            end else begin
              beat_cnt <= beat_cnt + BL_W'(1);
            end
          end
`ifdef TG_ACK_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            timeout  <= 1'b1;
            state    <= FIN;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        WR_GAP: begin
          if (burst_cnt == nb_q) begin
            state <= RD_INIT;
          end else begin
            state    <= WR_BURST;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
          end
        end

        RD_INIT: begin
          lfsr      <= seed_q;
          wb_addr_o <= base_q;
          burst_cnt <= '0;
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          state     <= RD_BURST;
        end

        RD_GAP: begin
          if (burst_cnt == nb_q) begin
            state <= FIN;
          end else begin
            state    <= RD_BURST;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
          end
        end

        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef TG_ACK_TIMEOUT_EN
          pass  <= (err_cnt == 16'd0) && !timeout;
`else
          pass  <= (err_cnt == 16'd0);
`endif
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_sdr_traffic_gen.md
Name: wb_sdr_traffic_gen

Overview:
Parametrised, synthesizable Wishbone master that exercises sdrc_top from the WB side.
- Writes N bursts of LFSR data from a base address, then reads the same region back and compares against the regenerated pattern.
- Reports error count, first failing address and pass/fail.
- Generalises the fixed single-stimulus harness: configurable data width, address width, burst length, burst count, byte mask and seed, so sdrc_top configurations can be soaked on-chip or in simulation without a software driver.

Parameters:
dw, 32, WB data width (multiple of 8).
APP_AW, 26, WB byte-address width.
BL_W, 4, burst-length field width; burst length = cfg_burst_len+1 (1..2^BL_W).
NB_W, 16, burst-count field width.
LFSR_TAPS, 32'h80200003, Galois feedback mask, dw bits.

Ports:
wb_clk_i  in  1  clock; all logic on rising edge.
wb_resetn  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; starts a run; ignored while busy=1.
cfg_base_addr  in  APP_AW  start byte address; low log2(dw/8) bits ignored (forced 0).
cfg_burst_len  in  BL_W  beats per burst minus 1.
cfg_num_bursts  in  NB_W  burst count; 0 = run completes immediately with pass=1.
cfg_seed  in  dw  LFSR seed; 0 is replaced by 1.
cfg_sel  in  dw/8  byte enables for all beats, also the compare mask.
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WB master controls.
wb_addr_o  out  APP_AW  byte address.
wb_dat_o  out  dw  write data.
wb_sel_o  out  dw/8  byte select (= latched cfg_sel).
wb_cti_o  out  3  010 incrementing, 111 last beat.
wb_ack_i  in  1  slave acknowledge.
wb_dat_i  in  dw  read data, valid with wb_ack_i.
busy  out  1  run in progress.
done  out  1  set at run end, held until next accepted start.
pass  out  1  valid when done; 1 iff err_cnt==0 (and no timeout).
err_cnt  out  16  mismatching beats, saturates at 16'hFFFF.
first_err_addr  out  APP_AW  address of first mismatch; 0 if none.

Behaviour:
- Reset (async, wb_resetn=0): every output 0, FSM to IDLE, LFSR = 1. Reset mid-burst drops cyc/stb immediately; no partial state is retained.
- On accepted start: latch all cfg_* inputs.
- FSM states: IDLE -> WR_BURST -> WR_GAP -> (WR_BURST | RD_INIT) -> RD_BURST -> RD_GAP -> (RD_BURST | FIN) -> IDLE.
- IDLE: start=1 latches cfg, loads LFSR with the seed, sets addr = base, clears err_cnt/first_err_addr/done, sets busy. Next state is WR_BURST, or FIN if cfg_num_bursts==0.
- WR_BURST/RD_BURST:
  - cyc=stb=1 for every cycle of the burst; we=1 only in WR_BURST.
  - Each ack advances: addr += dw/8 (wraps mod 2^APP_AW), LFSR steps one, beat counter increments.
  - wb_addr_o/wb_dat_o change only on the cycle after an ack; back-to-back acks are supported (one beat per clock).
  - cti=111 on the last beat, including single-beat bursts (cfg_burst_len=0); 010 otherwise.
- Burst end: the ack of the last beat moves to the GAP state. cyc/stb are low for exactly 1 cycle between bursts. The burst counter decides the next burst or the next phase.
- RD_INIT (1 cycle): LFSR reloaded with seed, addr reloaded with base.
- Compare on each read ack: mismatch = |((wb_dat_i ^ lfsr) & byte-expanded cfg_sel). On the first mismatch, capture wb_addr_o into first_err_addr. err_cnt increments and saturates.
- FIN (1 cycle): busy=0, done=1, pass=(err_cnt==0). Return to IDLE.
- LFSR step: lfsr = {1'b0, lfsr[dw-1:1]} ^ (lfsr[0] ? LFSR_TAPS : 0).
- start during busy: no effect. start in the same cycle as FIN: ignored; it is accepted from IDLE only.
- wb_ack_i while cyc=0: ignored.

Optional Feature:
TG_ACK_TIMEOUT_EN:
- Defined: adds parameter TO_CYC (default 255) and output port timeout (1 bit, reset 0).
  - A counter runs while stb=1 and no ack; it clears on each ack.
  - When the counter reaches TO_CYC: cyc/stb drop that cycle, timeout=1, then FIN with pass=0.
  - timeout is cleared by the next accepted start.
- Undefined: no counter, no timeout port; the FSM waits indefinitely for ack.

Test Plan:
1. Behavioural WB memory with 0-wait acks; base=0x100, burst_len=3, num_bursts=2, seed=1, sel=F -> write addresses 0x100,0x104..0x11C; cti 010,010,010,111 per burst; 1-cycle cyc gap; done=1, pass=1, err_cnt=0.
2. Same as 1, but memory flips bit 0 of word 0x108 after the write phase -> err_cnt=1, first_err_addr=0x108, pass=0.
3. burst_len=0, num_bursts=3 -> every beat cti=111, cyc low 1 cycle between beats, pass=1. sel=4'b0011 with memory corrupting byte 3 -> err_cnt=0.
4. APP_AW=26, base=0x3FFFFF8, burst_len=3 -> addresses 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004; readback pass=1.
5. Memory inserts random 0-3 wait states; start pulsed mid-run -> ignored. wb_resetn low mid-WR_BURST -> cyc/stb/busy/done 0 the same cycle; a new start runs cleanly to pass=1.
6. TG_ACK_TIMEOUT_EN defined, TO_CYC=16, slave never acks -> cyc drops 16 cycles after stb rise; timeout=1, done=1, pass=0.
